// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide for the EX stage.
// Radix-2 shift-add multiply, radix-2 restoring divide, 32 cycles each.
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hold,
  input  logic        kill,
  output logic        done,
  output logic        busy,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [5:0]  cnt;
  logic [2:0]  op;
  logic        sgn_a;
  logic        sgn_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] acc;
  logic [63:0] acc_nx;
  logic [31:0] res_nx;

  logic        sa_in;
  logic        sb_in;
  logic [31:0] ma_in;
  logic [31:0] mb_in;
  logic        div_zero;
  logic        div_ovf;
  logic        fast;
  logic [31:0] fast_res;

  logic [32:0] msum;
  logic [32:0] dpart;
  logic [32:0] ddiff;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rmd;

  assign sa_in = op_a[31] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                             (funct3 == 3'b100) | (funct3 == 3'b110));
  assign sb_in = op_b[31] & ((funct3 == 3'b001) | (funct3 == 3'b100) |
                             (funct3 == 3'b110));
  assign ma_in = sa_in ? (32'd0 - op_a) : op_a;
  assign mb_in = sb_in ? (32'd0 - op_b) : op_b;

  assign div_zero = funct3[2] & (op_b == 32'd0);
  assign div_ovf  = funct3[2] & ~funct3[0] &
                    (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
  assign fast     = div_zero | div_ovf;
  assign fast_res = div_zero ? (funct3[1] ? op_a : 32'hFFFF_FFFF)
                             : (funct3[1] ? 32'd0 : 32'h8000_0000);

  assign busy = (state == BUSY);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and the stall-release flag
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        done = ~start;
        if (start) state_nx = fast ? DONE : BUSY;
      end
      BUSY: begin
        if (cnt == 6'd31) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!hold) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (kill) state_nx = IDLE;
  end

  // One iteration step: shift-add for multiply, restoring step for divide
  always_comb begin
    msum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
    dpart = {acc[63:32], acc[31]};
    ddiff = dpart - {1'b0, mag_b};
    if (op[2]) begin
      if (ddiff[32]) acc_nx = {dpart[31:0], acc[30:0], 1'b0};
      else           acc_nx = {ddiff[31:0], acc[30:0], 1'b1};
    end else begin
      acc_nx = {msum, acc[31:1]};
    end
  end

  // Sign fix and result selection for the final iteration
  always_comb begin
    prod = (sgn_a ^ sgn_b) ? (64'd0 - acc_nx) : acc_nx;
    quo  = (sgn_a ^ sgn_b) ? (32'd0 - acc_nx[31:0]) : acc_nx[31:0];
    rmd  = sgn_a ? (32'd0 - acc_nx[63:32]) : acc_nx[63:32];
    case (op)
      3'b000:         res_nx = prod[31:0];
      3'b100, 3'b101: res_nx = quo;
      3'b110, 3'b111: res_nx = rmd;
      default:        res_nx = prod[63:32];
    endcase
  end

  // Operand capture, iteration and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 6'd0;
      op     <= 3'd0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      mag_a  <= 32'd0;
      mag_b  <= 32'd0;
      acc    <= 64'd0;
      result <= 32'd0;
    end else if (kill) begin
      cnt <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op    <= funct3;
            sgn_a <= sa_in;
            sgn_b <= sb_in;
            mag_a <= ma_in;
            mag_b <= mb_in;
            acc   <= funct3[2] ? {32'd0, ma_in} : {32'd0, mb_in};
            cnt   <= 6'd0;
            if (fast) result <= fast_res;
          end
        end
        BUSY: begin
          acc <= acc_nx;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) result <= res_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed checks of ex_muldiv_unit against a
// plain-arithmetic RV32M model with cycle-level timing.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        hold;
  logic        kill;
  logic        done;
  logic        busy;
  logic [31:0] result;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .hold   (hold),
    .kill   (kill),
    .done   (done),
    .busy   (busy),
    .result (result)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          p;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned up;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub;
        return up[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub;
        return up[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
    return f[2] && ((b == 0) ||
           (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Timing model: idle / iterating with cycles left / finished
  bit          m_idle = 1;
  bit          m_fin  = 0;
  int          m_left = 0;
  logic [31:0] m_res  = 0;
  logic [31:0] m_pend = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_idle <= 1;
      m_fin  <= 0;
      m_res  <= 0;
    end else if (kill) begin
      m_idle <= 1;
      m_fin  <= 0;
    end else if (m_idle) begin
      if (start) begin
        m_idle <= 0;
        if (is_fast(funct3, op_a, op_b)) begin
          m_fin <= 1;
          m_res <= ref_res(funct3, op_a, op_b);
        end else begin
          m_left <= 32;
          m_pend <= ref_res(funct3, op_a, op_b);
        end
      end
    end else if (m_fin) begin
      if (!hold) begin
        m_fin  <= 0;
        m_idle <= 1;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_fin <= 1;
        m_res <= m_pend;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc done", {31'd0, done}, m_idle ? {31'd0, ~start} : {31'd0, m_fin});
      check("cyc busy", {31'd0, busy}, {31'd0, !m_idle && !m_fin});
      check("cyc result", result, m_res);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit,
                        input int lat, input bit use_lit, input string nm);
    int n;
    if (use_lit) check({nm, " model"}, ref_res(f, a, b), lit);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1;
    step();
    start  = 0;
    funct3 = 3'($urandom);
    op_a   = $urandom;
    op_b   = $urandom;
    n = 1;
    while (done !== 1'b1 && n < 80) begin
      step();
      n++;
    end
    check({nm, " latency"}, n, lat);
    check({nm, " result"}, result, use_lit ? lit : ref_res(f, a, b));
    step();
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1; start = 0; funct3 = 0; op_a = 0; op_b = 0; hold = 0; kill = 0;
    step();
    step();
    rst = 0;
    chk_en = 1;
    check("reset done", {31'd0, done}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset result", result, 32'd0);
    start = 1;
    kill  = 1;
    #1;
    check("idle done follows start", {31'd0, done}, 32'd0);
    step();
    start = 0;
    kill  = 0;
    check("killed start not taken", {31'd0, busy}, 32'd0);
    step();

    vecs.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL 7x-3"});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU"});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "MULH"});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "MULHSU"});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "DIV -7/2"});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "REM -7/2"});
    vecs.push_back('{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "DIVU 5/0"});
    vecs.push_back('{3'd7, 32'd5, 32'd0, 32'h0000_0005, 1, "REMU 5/0"});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV ovf"});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "REM ovf"});
    vecs.push_back('{3'd0, 32'd0, 32'd12345, 32'd0, 33, "MUL 0x"});
    vecs.push_back('{3'd5, 32'd100, 32'd7, 32'd14, 33, "DIVU 100/7"});
    vecs.push_back('{3'd7, 32'd100, 32'd7, 32'd2, 33, "REMU 100/7"});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "MULH min"});
    vecs.push_back('{3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "DIV 7/-2"});
    vecs.push_back('{3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "REM 7/-2"});
    vecs.push_back('{3'd4, 32'd0, 32'd0, 32'hFFFF_FFFF, 1, "DIV 0/0"});
    vecs.push_back('{3'd6, 32'd0, 32'd5, 32'd0, 33, "REM 0/5"});

    foreach (vecs[i])
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat, 1,
             vecs[i].nm);

    for (int i = 0; i < 12; i++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rb = (i % 5 == 4) ? 32'd0 : $urandom;
      lat = is_fast(rf, ra, rb) ? 1 : 33;
      run_op(rf, ra, rb, 32'd0, lat, 0, "random");
    end

    // hold four cycles in the finished state
    hold = 1;
    begin
      int n;
      funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; start = 1;
      step();
      start = 0;
      op_a = 32'd1;
      n = 1;
      while (done !== 1'b1 && n < 80) begin
        step();
        n++;
      end
      check("hold latency", n, 33);
      check("hold result", result, 32'd14);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold done", {31'd0, done}, 32'd1);
      check("hold stable", result, 32'd14);
    end
    step();
    hold  = 0;
    start = 1;
    #1;
    check("hold last cycle done", {31'd0, done}, 32'd1);
    step();
    kill = 1;
    check("idle after hold", {31'd0, done}, 32'd0);
    check("idle after hold busy", {31'd0, busy}, 32'd0);
    step();
    kill  = 0;
    start = 0;
    check("post hold result", result, 32'd14);

    // kill at cycle 10
    funct3 = 3'd0; op_a = 32'd123; op_b = 32'd456; start = 1;
    step();
    start = 0;
    for (int i = 1; i < 10; i++) step();
    check("kill busy before", {31'd0, busy}, 32'd1);
    kill = 1;
    step();
    kill = 0;
    check("kill idle busy", {31'd0, busy}, 32'd0);
    check("kill idle done", {31'd0, done}, 32'd1);
    check("kill result kept", result, 32'd14);
    for (int i = 0; i < 40; i++) step();
    check("kill no update", result, 32'd14);

    // reset at cycle 20
    funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; start = 1;
    step();
    start = 0;
    for (int i = 1; i < 20; i++) step();
    rst = 1;
    step();
    rst = 0;
    check("rst result", result, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd1);
    for (int i = 0; i < 40; i++) step();
    check("rst no update", result, 32'd0);

    // reset while holding a finished result
    hold = 1;
    funct3 = 3'd5; op_a = 32'd5; op_b = 32'd0; start = 1;
    step();
    start = 0;
    check("fast done", {31'd0, done}, 32'd1);
    check("fast result", result, 32'hFFFF_FFFF);
    rst = 1;
    step();
    rst  = 0;
    hold = 0;
    check("rst in done result", result, 32'd0);
    check("rst in done busy", {31'd0, busy}, 32'd0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port start  input  1  valid RV32M instruction present in EX.
REQ-004 SHALL have port funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port op_a  input  32  rs1 operand, already forwarded.
REQ-006 SHALL have port op_b  input  32  rs2 operand, already forwarded.
REQ-007 SHALL have port hold  input  1  downstream stall (stall_mem); keeps a finished result in place.
REQ-008 SHALL have port kill  input  1  abort the in-flight operation.
REQ-009 SHALL have port done  output  1  drives hazard unit done_ex; low means EX must stall.
REQ-010 SHALL have port busy  output  1  high in BUSY state.
REQ-011 SHALL have port result  output  32  registered result, valid when done=1 in DONE.

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE; one operation in flight at a time.
REQ-013 SHALL compute done combinationally: IDLE -> ~start; BUSY -> 0; DONE -> 1.
REQ-014 SHALL accept an operation in IDLE when start=1 and kill=0: latch funct3, operands, signs, magnitudes; clear the iteration counter.
REQ-015 SHALL treat operands as signed for MULH/DIV/REM, rs1-only signed for MULHSU, unsigned otherwise; iterate on magnitudes and apply sign fix at the end.
REQ-016 SHALL multiply by radix-2 shift-add: one multiplier bit per cycle, 64-bit accumulator, 32 iterations; negate the 64-bit product when signs differ.
REQ-017 SHALL divide by radix-2 restoring: one quotient bit per cycle, 32 iterations; quotient sign = sign_a XOR sign_b; remainder sign = sign_a.
REQ-018 SHALL select result: MUL product[31:0]; MULH/MULHSU/MULHU product[63:32]; DIV/DIVU quotient; REM/REMU remainder.
REQ-019 SHALL use a 6-bit counter; BUSY lasts exactly 32 cycles; DONE entered on the cycle after counter=31; result registered on that transition.
REQ-020 SHALL have latency: accept at cycle 0, done=0 in cycles 0..32, done=1 from cycle 33.
REQ-021 SHALL handle divide-by-zero with no iteration, going IDLE->DONE in one cycle: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a.
REQ-022 SHALL handle signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF) with no iteration: DIV -> 0x80000000, REM -> 0x00000000, DONE after 1 cycle.
REQ-023 SHALL stay in DONE while hold=1 with result stable; SHALL return to IDLE the first cycle hold=0.
REQ-024 SHALL not accept a new operation in the DONE->IDLE transition cycle; the next start is sampled in IDLE.
REQ-025 SHALL give kill priority over all transitions except rst: next state IDLE, counter cleared, result unchanged.
REQ-026 SHALL ignore op_a/op_b/funct3 changes while BUSY or DONE.
REQ-027 SHALL treat operand x0 values like any other operand; no special zero-operand fast path except REQ-021.

Reset
REQ-028 SHALL on rst=1 at a clock edge force state IDLE, counter 0, result 0x00000000, busy 0; done then follows start.
REQ-029 SHALL abort an in-flight operation on rst mid-BUSY or mid-DONE with no done pulse for that operation.

Verification
REQ-030 SHALL cover MUL 7 x -3: start at cycle 0 -> done=0 through cycle 32, done=1 at 33, result 0xFFFFFFEB.
REQ-031 SHALL cover MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -> 0xFFFFFFFF.
REQ-032 SHALL cover DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF, each done at cycle 33.
REQ-033 SHALL cover DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 0x00000005, plus DIV 0x80000000/-1 -> 0x80000000, each with done=1 at cycle 1.
REQ-034 SHALL cover hold=1 for 4 cycles in DONE -> result stable and done=1 throughout, IDLE the cycle after hold drops.
REQ-035 SHALL cover kill at cycle 10 of BUSY -> IDLE next cycle, done=~start, no result update; rst at cycle 20 -> result 0.
